// File: rtl/pht_counter_bank_pkg.sv
// ---------------------------------------------------------------------------
// pht_counter_bank_pkg
// Shared definitions for the pattern history table counter bank:
//   - two-bit counter state names (strong/weak taken/not-taken)
//   - clear-sweep FSM state encoding
//   - table geometry shared with the downstream 16:1 prediction mux
// ---------------------------------------------------------------------------
package pht_counter_bank_pkg;

  // Table geometry; the mux select is the branch index, so these must agree
  localparam int PHT_NUM_ENTRIES = 16;
  localparam int PHT_IDX_WIDTH   = 4;

  // Two-bit saturating counter states; the MSB is the taken prediction
  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fsm_state_t;

endpackage

// File: rtl/pht_counter_bank_if.sv
// ---------------------------------------------------------------------------
// pht_counter_bank_if
// Branch-resolution update handshake into the counter bank.
//   upd_valid : update request
//   upd_idx   : counter to update
//   upd_taken : resolved outcome (1 = taken)
//   upd_ready : bank can accept an update this cycle
// master = the branch resolution unit, slave = the counter bank.
// ---------------------------------------------------------------------------
interface pht_counter_bank_if #(
  parameter int IDX_WIDTH = 4
);

  logic                 upd_valid;
  logic [IDX_WIDTH-1:0] upd_idx;
  logic                 upd_taken;
  logic                 upd_ready;

  modport master (
    output upd_valid,
    output upd_idx,
    output upd_taken,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_idx,
    input  upd_taken,
    output upd_ready
  );

endinterface

// File: rtl/pht_counter_bank_sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2
// A single two-bit saturating counter with synchronous load of its initial
// value and increment/decrement enables.
//   clk, rst_n : clock, asynchronous active-low reset (q -> INIT)
//   load       : reload INIT (wins over inc/dec)
//   inc, dec   : step toward STRONG_T / STRONG_NT, holding at the ends
//   q          : current counter state
// ---------------------------------------------------------------------------
module sat_counter2
  import pht_counter_bank_pkg::*;
#(
  parameter logic [1:0] INIT = WEAK_NT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= INIT;
    end else if (load) begin
      q <= INIT;
    end else if (inc && (q != STRONG_T)) begin
      q <= q + 2'd1;
    end else if (dec && (q != STRONG_NT)) begin
      q <= q - 2'd1;
    end
  end

endmodule

// File: rtl/pht_counter_bank.sv
// ---------------------------------------------------------------------------
// pht_counter_bank
// Pattern history table storage for the two-bit dynamic branch predictor.
// Holds NUM_ENTRIES saturating counters, applies branch-resolution updates,
// runs a one-entry-per-cycle clear sweep and keeps a saturating count of
// mispredicted updates.
//   clk, rst_n    : clock, asynchronous active-low reset
//   upd           : update handshake (slave side)
//   clear_req     : pulse that starts a clear sweep from IDLE
//   busy          : clear sweep in progress
//   counters_flat : counter i on bits [2i+1:2i], feeds the 16:1 mux
//   misp_count    : saturating mispredict count
// ---------------------------------------------------------------------------
module pht_counter_bank
  import pht_counter_bank_pkg::*;
#(
  parameter int         NUM_ENTRIES = PHT_NUM_ENTRIES,
  parameter int         IDX_WIDTH   = PHT_IDX_WIDTH,
  parameter logic [1:0] INIT_STATE  = WEAK_NT,
  parameter int         MISP_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pht_counter_bank_if.slave        upd,
  input  logic                     clear_req,
  output logic                     busy,
  output logic [2*NUM_ENTRIES-1:0] counters_flat,
  output logic [MISP_WIDTH-1:0]    misp_count
);

  fsm_state_t           state_q, state_d;
  logic [IDX_WIDTH-1:0] sweep_idx_q, sweep_idx_d;
  logic                 ready;
  logic                 accept;
  logic                 clear_start;
  logic                 pred_taken;
  logic                 misp_event;
  logic [NUM_ENTRIES-1:0] load_vec, inc_vec, dec_vec;
  logic [1:0]           cnt [NUM_ENTRIES];
  logic [MISP_WIDTH-1:0] misp_q;

  assign upd.upd_ready = ready;
  assign misp_count    = misp_q;

  // An update is only taken in IDLE, so updates and sweep writes never
  // target the same counter in the same cycle.
  assign accept      = upd.upd_valid && ready;
  assign clear_start = clear_req && (state_q == IDLE);

  // The prediction made for this branch was the MSB of the stored counter
  // before this update lands.
  assign pred_taken = cnt[upd.upd_idx][1];
  assign misp_event = accept && (pred_taken != upd.upd_taken);

  // FSM state and sweep index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  // Next state, handshake/busy outputs and the per-counter load/inc/dec
  // strobes. The sweep leaves CLEAR right after writing the last entry, so
  // busy is high for exactly NUM_ENTRIES cycles.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    busy        = 1'b0;
    ready       = 1'b0;
    load_vec    = '0;
    inc_vec     = '0;
    dec_vec     = '0;

    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (clear_req) begin
          state_d     = CLEAR;
          sweep_idx_d = '0;
        end
      end
      CLEAR: begin
        busy                  = 1'b1;
        load_vec[sweep_idx_q] = 1'b1;
        sweep_idx_d           = sweep_idx_q + IDX_WIDTH'(1);
        if (sweep_idx_q == IDX_WIDTH'(NUM_ENTRIES - 1)) begin
          state_d     = IDLE;
          sweep_idx_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (accept) begin
      if (upd.upd_taken) begin
        inc_vec[upd.upd_idx] = 1'b1;
      end else begin
        dec_vec[upd.upd_idx] = 1'b1;
      end
    end
  end

  // Mispredict statistics. Starting a sweep zeroes the count, but an update
  // accepted on that same edge is still counted on top of the zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misp_q <= '0;
    end else if (clear_start) begin
      misp_q <= MISP_WIDTH'(misp_event);
    end else if (misp_event && (misp_q != '1)) begin
      misp_q <= misp_q + MISP_WIDTH'(1);
    end
  end

  // Counter array, exposed flat for the prediction mux
  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_cnt
    sat_counter2 #(
      .INIT (INIT_STATE)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_vec[i]),
      .inc   (inc_vec[i]),
      .dec   (dec_vec[i]),
      .q     (cnt[i])
    );
    assign counters_flat[2*i +: 2] = cnt[i];
  end

endmodule

// File: tb/tb_pht_counter_bank.sv
// ---------------------------------------------------------------------------
// tb_pht_counter_bank
// Self-checking bench for pht_counter_bank. A behavioural table model
// (integer array, remaining-sweep count, clamped statistics) predicts every
// output; directed scenarios are followed by randomized traffic. The
// statistics counter is built 4 bits wide so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_pht_counter_bank;

  localparam int MW      = 4;
  localparam int MISPMAX = (1 << MW) - 1;

  logic          clk;
  logic          rst_n;
  logic          clear_req;
  logic          busy;
  logic [31:0]   counters_flat;
  logic [MW-1:0] misp_count;

  pht_counter_bank_if #(.IDX_WIDTH(4)) upd_if ();

  pht_counter_bank #(
    .NUM_ENTRIES (16),
    .IDX_WIDTH   (4),
    .INIT_STATE  (2'b01),
    .MISP_WIDTH  (MW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .upd           (upd_if),
    .clear_req     (clear_req),
    .busy          (busy),
    .counters_flat (counters_flat),
    .misp_count    (misp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model
  int model_cnt [16];
  int model_misp;
  int sweep_left;

  function automatic void resetModel();
    for (int i = 0; i < 16; i++) model_cnt[i] = 1;
    model_misp = 0;
    sweep_left = 0;
  endfunction

  function automatic logic [31:0] packFlat();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[2*i +: 2] = model_cnt[i][1:0];
    return r;
  endfunction

  // What one rising edge does to the table, in terms of the rules
  function automatic void modelEdge(logic v, int idx, logic tk, logic clr);
    if (sweep_left > 0) begin
      model_cnt[16 - sweep_left] = 1;
      sweep_left--;
    end else begin
      if (clr) model_misp = 0;
      if (v) begin
        if ((model_cnt[idx] >= 2) != tk && model_misp < MISPMAX) model_misp++;
        if (tk)  model_cnt[idx] = (model_cnt[idx] == 3) ? 3 : model_cnt[idx] + 1;
        else     model_cnt[idx] = (model_cnt[idx] == 0) ? 0 : model_cnt[idx] - 1;
      end
      if (clr) sweep_left = 16;
    end
  endfunction

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(string tag);
    checkOutput({tag, ":flat"},  counters_flat, packFlat());
    checkOutput({tag, ":misp"},  32'(misp_count), 32'(model_misp));
    checkOutput({tag, ":busy"},  32'(busy), 32'(sweep_left > 0));
    checkOutput({tag, ":ready"}, 32'(upd_if.upd_ready), 32'(sweep_left == 0));
  endtask

  // Drive one cycle of inputs, confirm nothing reaches counters_flat before
  // the edge, then advance the model with the edge.
  task automatic applyStimulus(logic v, logic [3:0] idx, logic tk, logic clr);
    upd_if.upd_valid = v;
    upd_if.upd_idx   = idx;
    upd_if.upd_taken = tk;
    clear_req        = clr;
    #1;
    checkOutput("pre_edge_flat", counters_flat, packFlat());
    @(posedge clk);
    modelEdge(v, int'(idx), tk, clr);
    #1;
    upd_if.upd_valid = 1'b0;
    clear_req        = 1'b0;
  endtask

  initial begin
    rst_n            = 1'b0;
    clear_req        = 1'b0;
    upd_if.upd_valid = 1'b0;
    upd_if.upd_idx   = '0;
    upd_if.upd_taken = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: reset values
    checkAll("reset");
    checkOutput("reset_const", counters_flat, 32'h5555_5555);

    // 2: taken updates to idx 3 saturate, one mispredict
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 4'd3, 1'b1, 1'b0);
      checkAll("t2_taken3");
    end
    checkOutput("t2_cnt3", 32'(counters_flat[7:6]), 32'd3);
    checkOutput("t2_misp", 32'(misp_count), 32'd1);

    // 3: not-taken updates to idx 15 saturate at 0, then taken mispredicts
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 4'd15, 1'b0, 1'b0);
      checkAll("t3_nt15");
    end
    checkOutput("t3_cnt15_low", 32'(counters_flat[31:30]), 32'd0);
    applyStimulus(1'b1, 4'd15, 1'b1, 1'b0);
    checkAll("t3_t15");
    checkOutput("t3_cnt15", 32'(counters_flat[31:30]), 32'd1);

    // 4: mixed values, then a clear sweep ignoring an update to idx 0
    applyStimulus(1'b1, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd9, 1'b0, 1'b0);
    checkAll("t4_prog");
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    checkAll("t4_start");
    for (int k = 0; k < 16; k++) begin
      if (k == 2) applyStimulus(1'b1, 4'd0, 1'b0, 1'b1);
      else        applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
      checkAll("t4_sweep");
    end
    checkOutput("t4_done_flat", counters_flat, 32'h5555_5555);
    checkOutput("t4_done_busy", 32'(busy), 32'd0);

    // 5: clear together with an update to idx 5 (counter 00)
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd2, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'd5, 1'b1, 1'b1);
    checkAll("t5_edge");
    checkOutput("t5_misp", 32'(misp_count), 32'd1);
    checkOutput("t5_cnt5", 32'(counters_flat[11:10]), 32'd1);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
      checkAll("t5_sweep");
    end
    checkOutput("t5_final", counters_flat, 32'h5555_5555);

    // 6: forced mispredicts saturate the statistics counter
    for (int k = 0; k < MISPMAX + 4; k++) begin
      int idx;
      idx = int'($urandom_range(0, 15));
      applyStimulus(1'b1, 4'(idx), model_cnt[idx] < 2, 1'b0);
      checkAll("t6_sat");
    end
    checkOutput("t6_misp_max", 32'(misp_count), 32'(MISPMAX));

    // 6: reset in the middle of a sweep aborts it
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b1);
    repeat (5) applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkAll("t6_midsweep");
    #2;
    rst_n = 1'b0;
    resetModel();
    #1;
    checkAll("t6_async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0);
    checkAll("t6_after_rst");

    // Randomized traffic, occasional clears
    for (int k = 0; k < 400; k++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 39) == 0));
      checkAll("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pht_counter_bank.md
Name: pht_counter_bank

Overview:
- Pattern history table storage for the two-bit dynamic branch predictor.
- Holds NUM_ENTRIES two-bit saturating counters and applies branch-resolution updates to them.
- Exposes every counter state in parallel on a flat bus; the top level slices that bus into the sixteen 2-bit inputs of the downstream 16:1 prediction mux, whose 4-bit select is the branch index.
- Also provides a sequenced table clear and a saturating mispredict counter.

Parameters:
- NUM_ENTRIES, 16, number of counters; fixed at 16 to match the 4-bit mux select.
- IDX_WIDTH, 4, index width; must equal log2(NUM_ENTRIES).
- INIT_STATE, 2'b01, counter value after reset and after clear (weakly not-taken).
- MISP_WIDTH, 16, width of the mispredict statistics counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- upd_valid  input  1  branch resolution update request.
- upd_idx  input  IDX_WIDTH  counter to update.
- upd_taken  input  1  resolved outcome: 1 = taken.
- upd_ready  output  1  update accepted when upd_valid & upd_ready at a rising edge.
- clear_req  input  1  single-cycle pulse that starts a table clear sweep.
- busy  output  1  clear sweep in progress.
- counters_flat  output  2*NUM_ENTRIES  counter i occupies bits [2i+1:2i].
- misp_count  output  MISP_WIDTH  saturating count of mispredicted updates.

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low (clk, rst_n).

Reset (rst_n low):
- All counters = INIT_STATE; counters_flat = 32'h5555_5555 at defaults.
- FSM = IDLE; sweep index = 0.
- misp_count = 0; busy = 0; upd_ready = 1.
- Reset asserted mid-sweep aborts the sweep immediately.

FSM states:
- IDLE: busy = 0, upd_ready = 1.
  - clear_req = 1 at an edge -> CLEAR, sweep index = 0.
- CLEAR: busy = 1, upd_ready = 0.
  - Each cycle writes INIT_STATE to counter[sweep index], then increments the index.
  - After index NUM_ENTRIES-1 is written -> IDLE.
  - busy is high for exactly 16 cycles.
  - clear_req is ignored while in CLEAR.
  - upd_valid is dropped while in CLEAR; no counter or statistics change.
- Entering CLEAR also zeroes misp_count on the same edge.

Update (on an accepted handshake):
- counter[upd_idx] changes as follows:
  - taken and counter < 3: increment.
  - taken and counter = 3: hold at 3.
  - not-taken and counter > 0: decrement.
  - not-taken and counter = 0: hold at 0.
- Latency: new value visible on counters_flat the cycle after acceptance. No combinational path from upd_* to counters_flat.
- Mispredict: the prediction is the pre-update counter MSB. If it differs from upd_taken, misp_count increments, saturating at all ones (no wrap).
- Simultaneous clear_req and upd_valid in IDLE: the update is applied on that edge (misp_count evaluated after the zeroing, i.e. it ends at 0 or 1) and the sweep starts next cycle. The sweep later overwrites the updated entry.
- Back-to-back updates to the same index on consecutive cycles each read the value written by the previous one. The storage is a register, so there is no hazard.
- upd_idx is only meaningful while upd_valid is high.

Decomposition:
- Shared package holds:
  - counter state constants: STRONG_NT = 2'b00, WEAK_NT = 2'b01, WEAK_T = 2'b10, STRONG_T = 2'b11;
  - FSM state encoding IDLE/CLEAR;
  - the NUM_ENTRIES/IDX_WIDTH constants shared with the mux select.
- One natural sub-module: sat_counter2, a single two-bit saturating counter with load (init) and inc/dec enable, instantiated NUM_ENTRIES times.
- Decode, FSM and statistics logic live in the top level.

Test Plan:
1. Reset release -> counters_flat = 32'h5555_5555, misp_count = 0, busy = 0, upd_ready = 1.
2. Four taken updates to idx 3 on consecutive cycles -> counter3 goes 01→10→11→11 (saturates), each visible one cycle later; misp_count = 1 (only the first, predicted NT); all other counters unchanged.
3. Three not-taken updates to idx 15 from reset -> 01→00→00; misp_count = 0; upd_taken = 1 on the next update -> 01, misp_count = 1.
4. Program mixed values, then pulse clear_req -> busy high for 16 cycles, upd_ready low; an update to idx 0 issued during the sweep has no effect; afterwards counters_flat = 32'h5555_5555 and misp_count = 0.
5. clear_req together with a taken update to idx 5 (counter 00) in IDLE -> misp_count = 1 after the edge, counter5 = 01, then the sweep runs and the final counter5 = 01.
6. Force 2^16 + 3 mispredicts (MISP_WIDTH reduced to 4 via parameter for runtime) -> misp_count holds at all ones; assert rst_n mid-sweep -> immediate return to reset values, busy = 0.
